// File: rtl/speed_level_pkg.sv
// Shared types for the operator speed-level controller: level width,
// level type and the per-button auto-repeat state encoding.
package speed_level_pkg;

    localparam int LVL_W = 4;

    typedef logic [LVL_W-1:0] level_t;

    typedef enum logic [1:0] {
        RPT_IDLE,
        RPT_DELAY,
        RPT_REPEAT
    } rpt_state_e;

endpackage

// File: rtl/btn_debounce.sv
// Button conditioner: 2-flop synchroniser, counting debouncer holding the
// accepted stable value, and a rising-edge detector on that stable value.
module btn_debounce #(
    parameter int DEB_CNT = 1000000
) (
    input  logic Clk,
    input  logic Rst,
    input  logic Raw,
    output logic Stable,
    output logic Rise
);

    localparam int CNT_W = (DEB_CNT > 1) ? $clog2(DEB_CNT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CNT - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_stable;
    logic             r_stableD;
    logic [CNT_W-1:0] r_cnt;

    // Bring the asynchronous button into the clock domain.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= Raw;
            r_sync2 <= r_sync1;
        end
    end

    // Accept a new value only after it has differed from the stable one for DEB_CNT cycles.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            r_stable <= 1'b0;
            r_cnt    <= '0;
        end else if (r_sync2 == r_stable) begin
            r_cnt <= '0;
        end else if (r_cnt == CNT_LAST) begin
            r_stable <= r_sync2;
            r_cnt    <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Delayed copy of the stable value for edge detection.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            r_stableD <= 1'b0;
        end else begin
            r_stableD <= r_stable;
        end
    end

    assign Stable = r_stable;
    assign Rise   = r_stable & ~r_stableD;

endmodule

// File: rtl/speed_level_ctrl.sv
// Operator speed-level controller: debounced Up/Down buttons step a
// saturating 4-bit level that feeds the modulated clock divider.
// Optional auto-repeat while a button is held: define SPEED_LEVEL_AUTOREPEAT_EN.
module speed_level_ctrl
    import speed_level_pkg::*;
#(
    parameter int DEB_CNT  = 1000000,
    parameter int LVL_INIT = 1,
    parameter int LVL_MIN  = 1,
    parameter int LVL_MAX  = 15,
    parameter int REP_DLY  = 50000000,
    parameter int REP_RATE = 10000000
) (
    input  logic   Clk,
    input  logic   Rst,
    input  logic   BtnUp,
    input  logic   BtnDn,
    input  logic   Hold,
    output level_t Level,
    output logic   LevelChg,
    output logic   AtMax,
    output logic   AtMin
);

    localparam level_t L_INIT = level_t'(LVL_INIT);
    localparam level_t L_MIN  = level_t'(LVL_MIN);
    localparam level_t L_MAX  = level_t'(LVL_MAX);

    // Index 0 is the Up button, index 1 the Down button.
    logic [1:0] w_stable;
    logic [1:0] w_rise;
    logic       w_upReq;
    logic       w_dnReq;

    level_t     r_level;
    logic       r_levelChg;
    logic       r_atMax;
    logic       r_atMin;
    level_t     w_nextLevel;
    logic       w_change;

    btn_debounce #(.DEB_CNT(DEB_CNT)) u_debUp (
        .Clk    (Clk),
        .Rst    (Rst),
        .Raw    (BtnUp),
        .Stable (w_stable[0]),
        .Rise   (w_rise[0])
    );

    btn_debounce #(.DEB_CNT(DEB_CNT)) u_debDn (
        .Clk    (Clk),
        .Rst    (Rst),
        .Raw    (BtnDn),
        .Stable (w_stable[1]),
        .Rise   (w_rise[1])
    );

`ifdef SPEED_LEVEL_AUTOREPEAT_EN
    localparam int RPT_MAX = (REP_DLY > REP_RATE) ? REP_DLY : REP_RATE;
    localparam int RCW     = (RPT_MAX > 1) ? $clog2(RPT_MAX) : 1;
    localparam logic [RCW-1:0] DLY_LAST  = RCW'(REP_DLY - 1);
    localparam logic [RCW-1:0] RATE_LAST = RCW'(REP_RATE - 1);

    rpt_state_e     r_rptState   [2];
    rpt_state_e     w_rptNext    [2];
    logic [RCW-1:0] r_rptCnt     [2];
    logic [RCW-1:0] w_rptCntNext [2];
    logic [1:0]     w_rptPulse;

    // Repeat FSM state and counter registers, one set per button.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            for (int i = 0; i < 2; i++) begin
                r_rptState[i] <= RPT_IDLE;
                r_rptCnt[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                r_rptState[i] <= w_rptNext[i];
                r_rptCnt[i]   <= w_rptCntNext[i];
            end
        end
    end

    // The delay expiry itself issues the first repeat step, then one every REP_RATE cycles.
    always_comb begin
        w_rptPulse = 2'b00;
        for (int i = 0; i < 2; i++) begin
            w_rptNext[i]    = r_rptState[i];
            w_rptCntNext[i] = r_rptCnt[i];
            case (r_rptState[i])
                RPT_IDLE: begin
                    if (w_rise[i]) begin
                        w_rptNext[i]    = RPT_DELAY;
                        w_rptCntNext[i] = '0;
                    end
                end
                RPT_DELAY: begin
                    if (r_rptCnt[i] == DLY_LAST) begin
                        w_rptNext[i]    = RPT_REPEAT;
                        w_rptCntNext[i] = '0;
                        w_rptPulse[i]   = 1'b1;
                    end else begin
                        w_rptCntNext[i] = r_rptCnt[i] + 1'b1;
                    end
                end
                RPT_REPEAT: begin
                    if (r_rptCnt[i] == RATE_LAST) begin
                        w_rptCntNext[i] = '0;
                        w_rptPulse[i]   = 1'b1;
                    end else begin
                        w_rptCntNext[i] = r_rptCnt[i] + 1'b1;
                    end
                end
                default: begin
                    w_rptNext[i]    = RPT_IDLE;
                    w_rptCntNext[i] = '0;
                end
            endcase
            if (!w_stable[i]) begin
                w_rptNext[i]    = RPT_IDLE;
                w_rptCntNext[i] = '0;
                w_rptPulse[i]   = 1'b0;
            end
        end
    end

    assign w_upReq = w_rise[0] | w_rptPulse[0];
    assign w_dnReq = w_rise[1] | w_rptPulse[1];
`else
    assign w_upReq = w_rise[0];
    assign w_dnReq = w_rise[1];
`endif

    // Saturating step decision; bounds are checked before stepping so no wrap can occur.
    always_comb begin
        w_nextLevel = r_level;
        w_change    = 1'b0;
        if (!Hold) begin
            if (w_upReq && !w_dnReq && (r_level < L_MAX)) begin
                w_nextLevel = r_level + 1'b1;
                w_change    = 1'b1;
            end else if (w_dnReq && !w_upReq && (r_level > L_MIN)) begin
                w_nextLevel = r_level - 1'b1;
                w_change    = 1'b1;
            end
        end
    end

    // Level register with change pulse and bound flags updated in the same cycle.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            r_level    <= L_INIT;
            r_levelChg <= 1'b0;
            r_atMax    <= (L_INIT == L_MAX);
            r_atMin    <= (L_INIT == L_MIN);
        end else begin
            r_level    <= w_nextLevel;
            r_levelChg <= w_change;
            r_atMax    <= (w_nextLevel == L_MAX);
            r_atMin    <= (w_nextLevel == L_MIN);
        end
    end

    assign Level    = r_level;
    assign LevelChg = r_levelChg;
    assign AtMax    = r_atMax;
    assign AtMin    = r_atMin;

endmodule

// File: doc/speed_level_ctrl.md
# speed_level_ctrl

Operator speed-level controller: debounces raw Up/Down pushbuttons, converts presses into a saturating 4-bit speed level, and drives the level input of the downstream modulated clock divider. Sits between the board buttons and the divider. The level is held in a register, so the divider sees a glitch-free value that changes at most once per cycle.

## Interface
- `DEB_CNT`, 1000000: stable-sample cycles required to accept a button change (10 ms at 100 MHz).
- `LVL_INIT`, 1: level loaded at reset.
- `LVL_MIN`, 1: lower saturation bound.
- `LVL_MAX`, 15: upper saturation bound. Must satisfy `LVL_MIN` ≤ `LVL_INIT` ≤ `LVL_MAX` ≤ 15.
- `REP_DLY`, 50000000: hold time before auto-repeat starts. Used only with the macro.
- `REP_RATE`, 10000000: cycles between repeated steps. Used only with the macro.
- `Clk`  in  1  system clock (100 MHz).
- `Rst`  in  1  asynchronous, active-low reset.
- `BtnUp`  in  1  raw, asynchronous Up button, active-high.
- `BtnDn`  in  1  raw, asynchronous Down button, active-high.
- `Hold`  in  1  synchronous level freeze. When high, all step requests are discarded, not queued.
- `Level`  out  4  current level, registered. Feeds the divider's level input.
- `LevelChg`  out  1  one-cycle pulse in the same cycle `Level` takes a new value.
- `AtMax`  out  1  `Level == LVL_MAX`, registered.
- `AtMin`  out  1  `Level == LVL_MIN`, registered.

## Operation
- Each button goes through a 2-flop synchroniser, then a debouncer. The debouncer has a stable bit `S` and a counter `C`.
  - While the synced value equals `S`, `C` stays at 0.
  - While the synced value differs from `S`, `C` increments. When `C == DEB_CNT-1`, `S` takes the synced value and `C` returns to 0.
  - Any bounce back to `S` before that point clears `C`.
- A step request is the rising edge of `S`: `S` is registered, and the request is `S & ~S_d`. Falling edges produce no request.
- Step rules:
  - Up request only: `Level` increments, saturating at `LVL_MAX`.
  - Down request only: `Level` decrements, saturating at `LVL_MIN`.
  - Up and Down requests in the same cycle: no change.
  - A request that is saturated, blocked by `Hold`, or cancelled by the opposite button produces no `LevelChg`.
- Arithmetic is 4-bit unsigned. Compare against the bounds before stepping; never rely on wrap-around. 15+1 and 0-1 are impossible by construction.
- `AtMax`/`AtMin` update in the same cycle as `Level`.

## Timing
- Reset values:
  - `Level = LVL_INIT`, `LevelChg = 0`.
  - `AtMax`/`AtMin` take the reset-level comparisons.
  - Synchronisers, `S`, `S_d` and all counters are 0. The repeat FSM is in IDLE.
- Latency: a raw press held clean produces the `Level` update and `LevelChg` exactly `DEB_CNT+3` cycles after the first sampling edge that sees it. The breakdown is 2 synchroniser cycles, `DEB_CNT-1` counting cycles, 1 cycle to update `S`, and 1 cycle for the edge detect plus level register.
- Release is debounced identically but causes no level change.
- Reset asserted mid-count or mid-repeat aborts everything immediately. After release, a button still held low-to-high is treated as a fresh press (`S` restarts at 0).
- At most one step per cycle.

## Configuration
- `SPEED_LEVEL_AUTOREPEAT_EN` defined: a 3-state FSM runs per button.
  - IDLE → DELAY on the `S` rising edge, which also produces the normal single step.
  - DELAY counts `REP_DLY` cycles, then moves to REPEAT.
  - REPEAT issues one step request every `REP_RATE` cycles.
  - Any state → IDLE when `S` falls.
  - Repeat requests obey the same saturation, `Hold` and simultaneous-button rules. While both buttons are in REPEAT, their requests cancel.
- Macro undefined: there is no FSM and no repeat counters. The edge request is the only source of steps, and `REP_DLY`/`REP_RATE` are unused.

## Structure
- Package `speed_level_pkg`:
  - `LVL_W = 4`
  - `typedef logic [LVL_W-1:0] level_t`
  - repeat-FSM state enum `{RPT_IDLE, RPT_DELAY, RPT_REPEAT}`
- Sub-module `btn_debounce` (parameter `DEB_CNT`; ports `Clk`, `Rst`, `Raw`, `Stable`, `Rise`) contains the synchroniser, counter and edge detect. It is instanced twice.
- Level register, saturation logic and the optional repeat FSMs live in the top module.

## Test plan
Bench parameters: `DEB_CNT=4`, `LVL_INIT=1`, `LVL_MIN=1`, `LVL_MAX=15`, `REP_DLY=20`, `REP_RATE=5`.
- **Clean press:** `BtnUp` high for 20 cycles → `Level` 1→2 with a `LevelChg` pulse exactly 7 cycles after the first sampling edge. Release → no further change.
- **Bounce rejection:** `BtnUp` toggled with 2-cycle pulses for 30 cycles, then low → `Level` stays 1 and `LevelChg` is never asserted.
- **Saturation:** 20 clean Up presses → `Level` reaches 15 with `AtMax=1`. Exactly 14 `LevelChg` pulses are seen. A further Down press gives 14 and `AtMax=0`.
- **Simultaneous and Hold:** Up and Down pressed on the same cycle → no change. Up pressed while `Hold=1` → no change, and no step after `Hold` drops while the button is still held.
- **Reset mid-operation:** drop `Rst` during the debounce count with `Level=6` → `Level=1` asynchronously and all outputs at reset values. Release `Rst` with `BtnUp` still held → one step to 2 after `DEB_CNT+3` cycles.
- **Auto-repeat (macro defined):** hold `BtnDn` from `Level=10` → step to 9, then after 20 cycles one step every 5 cycles, stopping at 1 with `AtMin=1`. With the macro undefined, the same stimulus gives a single step to 9.
